// File: rtl/pci_pkg.sv
// Shared PCI definitions: arbiter state encoding, bus command codes and a width helper.
// No logic; types and constants only.
// Imported by the arbiter, its picker and the bus interface agents.
package pci_pkg;

  // Arbiter states: GAP = all grants high, PARK = idle bus parked on one master,
  // GRANTED = a master holds GNT# but has not started, OWNED = transaction running.
  typedef enum logic [1:0] {
    ARB_GAP     = 2'd0,
    ARB_PARK    = 2'd1,
    ARB_GRANTED = 2'd2,
    ARB_OWNED   = 2'd3
  } arb_state_e;

  // C/BE# command encodings driven during the PCI address phase.
  typedef enum logic [3:0] {
    CMD_INT_ACK       = 4'h0,
    CMD_SPECIAL       = 4'h1,
    CMD_IO_READ       = 4'h2,
    CMD_IO_WRITE      = 4'h3,
    CMD_MEM_READ      = 4'h6,
    CMD_MEM_WRITE     = 4'h7,
    CMD_CFG_READ      = 4'hA,
    CMD_CFG_WRITE     = 4'hB,
    CMD_MEM_READ_MULT = 4'hC,
    CMD_DUAL_ADDR     = 4'hD,
    CMD_MEM_READ_LINE = 4'hE,
    CMD_MEM_WRITE_INV = 4'hF
  } pci_cmd_e;

  // Bits needed to hold an index in 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// Round-robin picker: first active request strictly after last_i, wrapping around.
// Purely combinational, zero latency.
// No flow control; any_o flags that pick_o is meaningful.
module pci_rr_pick
  import pci_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  localparam int IW = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IW-1:0]          last_i,
  output logic [IW-1:0]          pick_o,
  output logic                   any_o
);

  // Scan last+1 .. last+NUM_MASTERS so the previous winner is checked last.
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    found  = 1'b0;
    idx    = '0;
    pick_o = last_i;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = IW'((int'(last_i) + k) % NUM_MASTERS);
      if (!found && req_i[idx]) begin
        pick_o = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI arbiter: round-robin GNT# from REQ#, hidden arbitration, parking, grant timeout.
// Grants are registered; a new holder appears two clocks after REQ# on a parked idle bus.
// Every change of holder passes through a clock with all GNT# high.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int PARK_MASTER = 0,
  parameter int GNT_TIMEOUT = 16,
  localparam int IW = idx_width(NUM_MASTERS),
  localparam int CW = idx_width(GNT_TIMEOUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_n_i,
  output logic [NUM_MASTERS-1:0] gnt_n_o,
  input  logic                   frame_n_i,
  input  logic                   irdy_n_i,
  output logic [IW-1:0]          owner_o,
  output logic                   owner_valid_o,
  output logic                   timeout_evt_o
);

  localparam logic [NUM_MASTERS-1:0] ONE      = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTERS-1:0] ALL_HIGH = '1;
  localparam logic [IW-1:0]          PARK_IDX = IW'(PARK_MASTER);
  localparam logic [IW-1:0]          LAST_RST = IW'(NUM_MASTERS - 1);
  localparam logic [CW-1:0]          CNT_LAST = CW'(GNT_TIMEOUT - 1);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] gnt_n_q;
  logic [IW-1:0]          owner_q;
  logic [IW-1:0]          last_q;
  logic [CW-1:0]          cnt_q;
  logic                   owner_valid_q;
  logic                   timeout_q;
  logic                   frame_n_q;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] owner_oh;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IW-1:0]          pick;
  logic                   any_req;
  logic                   other_req;
  logic                   owner_req;
  logic                   bus_idle;
  logic                   start;

  assign req       = ~req_n_i;
  assign owner_oh  = ONE << owner_q;
  assign pick_oh   = ONE << pick;
  assign other_req = |(req & ~owner_oh);
  assign owner_req = |(req & owner_oh);
  assign bus_idle  = frame_n_i & irdy_n_i;
  // A new transaction begins on the falling edge of FRAME# while IRDY# is still high.
  assign start     = frame_n_q & ~frame_n_i & irdy_n_i;

  pci_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_pick (
    .req_i (req),
    .last_i(last_q),
    .pick_o(pick),
    .any_o (any_req)
  );

  // Arbitration FSM; grant, owner and event outputs are all registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ARB_GAP;
      gnt_n_q       <= ALL_HIGH;
      owner_q       <= '0;
      last_q        <= LAST_RST;
      cnt_q         <= '0;
      owner_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      frame_n_q     <= 1'b1;
    end else begin
      frame_n_q <= frame_n_i;
      timeout_q <= 1'b0;
      case (state_q)
        ARB_GAP: begin
          owner_valid_q <= 1'b1;
          if (any_req) begin
            state_q <= ARB_GRANTED;
            gnt_n_q <= ~pick_oh;
            owner_q <= pick;
            last_q  <= pick;
            cnt_q   <= '0;
          end else begin
            state_q <= ARB_PARK;
            gnt_n_q <= ~(ONE << PARK_IDX);
            owner_q <= PARK_IDX;
          end
        end
        ARB_PARK: begin
          // Parked master may start without ever raising REQ#.
          if (start) begin
            state_q <= ARB_OWNED;
          end else if (other_req) begin
            state_q       <= ARB_GAP;
            gnt_n_q       <= ALL_HIGH;
            owner_valid_q <= 1'b0;
          end else if (owner_req) begin
            state_q <= ARB_GRANTED;
            last_q  <= owner_q;
            cnt_q   <= '0;
          end
        end
        ARB_GRANTED: begin
          // Start wins over a simultaneous timeout.
          if (start) begin
            state_q <= ARB_OWNED;
          end else if (!owner_req) begin
            state_q       <= ARB_GAP;
            gnt_n_q       <= ALL_HIGH;
            owner_valid_q <= 1'b0;
          end else if (bus_idle) begin
            if (cnt_q == CNT_LAST) begin
              state_q       <= ARB_GAP;
              gnt_n_q       <= ALL_HIGH;
              owner_valid_q <= 1'b0;
              timeout_q     <= 1'b1;
              cnt_q         <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ARB_OWNED: begin
          // Hidden arbitration: hand off while the current burst is still running.
          if (other_req) begin
            state_q       <= ARB_GAP;
            gnt_n_q       <= ALL_HIGH;
            owner_valid_q <= 1'b0;
          end else if (bus_idle) begin
            if (owner_req) begin
              state_q <= ARB_GRANTED;
              cnt_q   <= '0;
            end else begin
              state_q       <= ARB_GAP;
              gnt_n_q       <= ALL_HIGH;
              owner_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q       <= ARB_GAP;
          gnt_n_q       <= ALL_HIGH;
          owner_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_n_o       = gnt_n_q;
  assign owner_o       = owner_q;
  assign owner_valid_o = owner_valid_q;
  assign timeout_evt_o = timeout_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter: reset, single grant, rotation, timeout,
// hidden arbitration and asynchronous reset, with a grant-handover log as scoreboard.
module tb_pci_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_n = 4'hF;
  logic [3:0] gnt_n;
  logic       frame_n = 1'b1;
  logic       irdy_n = 1'b1;
  logic [1:0] owner;
  logic       owner_valid;
  logic       timeout_evt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int holder;
    int gap;
  } gevt_t;

  gevt_t      glog[$];
  int         exp_q[$];
  int         gap_run = 0;
  logic [3:0] prev_gnt = 4'hF;

  always #5 clk = ~clk;

  pci_arbiter #(
    .NUM_MASTERS(4),
    .PARK_MASTER(0),
    .GNT_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_n_i      (req_n),
    .gnt_n_o      (gnt_n),
    .frame_n_i    (frame_n),
    .irdy_n_i     (irdy_n),
    .owner_o      (owner),
    .owner_valid_o(owner_valid),
    .timeout_evt_o(timeout_evt)
  );

  function automatic int holder_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (!g[i[1:0]]) return i;
    return -1;
  endfunction

  // Reference round-robin: first requester after 'last', wrapping.
  function automatic int rr_model(input int last, input logic [3:0] reqv);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (reqv[i[1:0]]) return i;
    end
    return -1;
  endfunction

  // Grant monitor: one-hot-or-none every cycle, and a log of each new holder with its gap length.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(~gnt_n)) begin
      errors++;
      $display("FAIL gnt_onehot t=%0t gnt_n=%b required at most one low bit", $time, gnt_n);
    end
    if (gnt_n == 4'hF) begin
      gap_run++;
    end else if (prev_gnt == 4'hF || gnt_n != prev_gnt) begin
      glog.push_back('{holder: holder_of(gnt_n), gap: gap_run});
      gap_run = 0;
    end
    prev_gnt = gnt_n;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; req_n = 4'hF; frame_n = 1'b1; irdy_n = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got %0d required %0d", name, $time, act, req);
    end
  endtask

  task automatic wait_log(output gevt_t e, output bit ok);
    int n;
    n = 0;
    while (glog.size() == 0 && n < 64) begin
      tick();
      n++;
    end
    ok = (glog.size() != 0);
    e = '{holder: -1, gap: -1};
    if (ok) e = glog.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b0; req_n = 4'hF; frame_n = 1'b1; irdy_n = 1'b1;
    tick(2);
    chk("rst_gnt_n", int'(gnt_n), 15);
    chk("rst_owner_valid", int'(owner_valid), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_timeout_evt", int'(timeout_evt), 0);
    rst = 1'b1;
    #1;
    chk("gap_after_rst", int'(gnt_n), 15);
    tick();
    chk("park_gnt_n", int'(gnt_n), 4'b1110);
    chk("park_owner_valid", int'(owner_valid), 1);
    chk("park_owner", int'(owner), 0);
  endtask

  task automatic test_single_grant();
    do_reset();
    req_n = 4'b1011;
    tick();
    chk("single_gap", int'(gnt_n), 15);
    chk("single_gap_valid", int'(owner_valid), 0);
    tick();
    chk("single_grant", int'(gnt_n), 4'b1011);
    chk("single_owner", int'(owner), 2);
    frame_n = 1'b0;
    tick();
    irdy_n = 1'b0;
    req_n = 4'hF;
    tick();
    // Owned transaction keeps its grant after REQ# is dropped.
    chk("single_owned_hold", int'(gnt_n), 4'b1011);
    frame_n = 1'b1; irdy_n = 1'b1;
    tick();
    chk("single_end_gap", int'(gnt_n), 15);
    tick();
    chk("single_repark", int'(gnt_n), 4'b1110);
    chk("single_repark_owner", int'(owner), 0);
  endtask

  task automatic test_round_robin();
    int    last_m;
    gevt_t e;
    bit    ok;
    int    expv;
    do_reset();
    glog.delete(); exp_q.delete();
    last_m = 3;
    for (int t = 0; t < 5; t++) begin
      expv = rr_model(last_m, 4'hF);
      exp_q.push_back(expv);
      last_m = expv;
    end
    req_n = 4'h0;
    for (int t = 0; t < 5; t++) begin
      wait_log(e, ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL rr_grant_wait t=%0t no grant within 64 clocks, required holder", $time);
        break;
      end
      expv = exp_q.pop_front();
      chk("rr_holder", e.holder, expv);
      chk("rr_gap_len", e.gap, 1);
      frame_n = 1'b0; irdy_n = 1'b1;
      tick();
      irdy_n = 1'b0;
      tick(2);
      frame_n = 1'b1; irdy_n = 1'b1;
      tick();
    end
    req_n = 4'hF;
    tick(3);
  endtask

  task automatic test_timeout();
    int         n;
    int         held;
    int         last_m;
    int         expv;
    int         h;
    logic [3:0] reqv;
    gevt_t      e;
    bit         ok;
    do_reset();
    req_n = 4'b1101;
    n = 0;
    while (gnt_n !== 4'b1101 && n < 10) begin tick(); n++; end
    held = 0;
    while (gnt_n === 4'b1101 && held < 40) begin held++; tick(); end
    chk("to_held_clocks", held, 16);
    chk("to_evt_pulse", int'(timeout_evt), 1);
    chk("to_gnt_dropped", int'(gnt_n), 15);
    glog.delete(); exp_q.delete();
    last_m = 1;
    reqv = 4'b0111;
    req_n = ~reqv;
    exp_q.push_back(rr_model(last_m, reqv));
    tick();
    chk("to_evt_one_clock", int'(timeout_evt), 0);
    for (int s = 0; s < 3; s++) begin
      wait_log(e, ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL to_grant_wait t=%0t no grant within 64 clocks", $time);
        break;
      end
      expv = exp_q.pop_front();
      chk("to_order_holder", e.holder, expv);
      h = e.holder;
      if (h >= 0) req_n[h[1:0]] = 1'b1;
      reqv[expv[1:0]] = 1'b0;
      last_m = expv;
      if (reqv != 4'b0) exp_q.push_back(rr_model(last_m, reqv));
    end
    req_n = 4'hF;
    tick(3);
  endtask

  task automatic test_hidden_arb();
    int bad;
    do_reset();
    req_n = 4'b1110;
    tick();
    chk("ha_park_to_grant", int'(gnt_n), 4'b1110);
    frame_n = 1'b0; irdy_n = 1'b1;
    tick();
    irdy_n = 1'b0;
    tick();
    req_n = 4'b0110;
    tick();
    chk("ha_gap", int'(gnt_n), 15);
    tick();
    chk("ha_grant3_busy", int'(gnt_n), 4'b0111);
    chk("ha_owner3", int'(owner), 3);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt_n !== 4'b0111 || timeout_evt !== 1'b0) bad++;
    end
    chk("ha_no_count_busy", bad, 0);
    frame_n = 1'b1; irdy_n = 1'b1; req_n = 4'b0111;
    tick();
    frame_n = 1'b0;
    tick();
    chk("ha_m3_start", int'(gnt_n), 4'b0111);
    irdy_n = 1'b0; req_n = 4'hF;
    tick();
    chk("ha_m3_owned", int'(gnt_n), 4'b0111);
    frame_n = 1'b1; irdy_n = 1'b1;
    tick();
    chk("ha_end_gap", int'(gnt_n), 15);
    tick();
    chk("ha_repark", int'(gnt_n), 4'b1110);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_n = 4'b1011;
    tick(2);
    frame_n = 1'b0;
    tick();
    irdy_n = 1'b0;
    tick();
    chk("rm_pre_owned", int'(gnt_n), 4'b1011);
    #2;
    rst = 1'b0;
    #1;
    chk("rm_gnt_async", int'(gnt_n), 15);
    chk("rm_valid_async", int'(owner_valid), 0);
    chk("rm_timeout_async", int'(timeout_evt), 0);
    chk("rm_owner_async", int'(owner), 0);
    frame_n = 1'b1; irdy_n = 1'b1; req_n = 4'hF;
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_timeout();
    test_hidden_arb();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
